// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host FSM states, command bytes, parity helper.
// Imported by the host transmitter and reusable by the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK_WAIT
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // Bit index of the stop bit; the next falling edge carries the ACK.
    localparam logic [3:0] STOP_BIT = 4'd10;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus stable-sample filter for one PS/2 line.
// Ports: clk, reset (async active-low), line_in (raw), line_out (filtered, resets to 1).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_out
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q counts consecutive samples that disagree with the filtered
    // value; the FILTER_LEN-th one in a row flips the output.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign line_out = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, ACK.
// Ports: tx_data/tx_valid/tx_ready request, tx_busy, tx_done/tx_ack_err/tx_timeout pulses,
// ps2_clk_in/ps2_data_in raw lines, ps2_clk_oe/ps2_data_oe open-drain pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES        = 5000,
    parameter int START_TIMEOUT_CYCLES  = 750000,
    parameter int PACKET_TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN            = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                           INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_P = (MAX_A > PACKET_TIMEOUT_CYCLES) ?
                           MAX_A : PACKET_TIMEOUT_CYCLES;
    localparam int TW    = $clog2(MAX_P) + 1;

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          ack_err_q, ack_err_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          to_q, to_d;
    logic          clk_prev_q;

    logic          clk_f;
    logic          data_f;
    logic          fall;
    logic [TW-1:0] limit;
    logic          cur_bit;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk      (clk),
        .reset    (reset),
        .line_in  (ps2_clk_in),
        .line_out (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk      (clk),
        .reset    (reset),
        .line_in  (ps2_data_in),
        .line_out (data_f)
    );

    assign fall = clk_prev_q & ~clk_f;

    // Before the first edge the start window applies, afterwards the packet window.
    assign limit = (bit_cnt_q == 4'd0) ? TW'(START_TIMEOUT_CYCLES - 1)
                                       : TW'(PACKET_TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            ack_err_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            ack_err_q  <= ack_err_d;
            done_q     <= done_d;
            err_q      <= err_d;
            to_q       <= to_d;
            clk_prev_q <= clk_f;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        to_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                if (tx_valid) begin
                    data_d  = tx_data;
                    par_d   = odd_parity(tx_data);
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = REQ;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REQ: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (fall) begin
                    // First edge restarts the timer for the packet window.
                    timer_d   = (bit_cnt_q == 4'd0) ? '0 : timer_q + 1'b1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == STOP_BIT) begin
                        ack_err_d = data_f;
                        state_d   = ACK_WAIT;
                    end
                end else if (timer_q >= limit) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ACK_WAIT: begin
                if (clk_f && data_f) begin
                    done_d  = ~ack_err_q;
                    err_d   = ack_err_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame bit on the wire for the current bit_cnt; 1 means release.
    always_comb begin
        cur_bit = 1'b1;
        if (bit_cnt_q == 4'd0) begin
            cur_bit = 1'b0;
        end else if (bit_cnt_q <= 4'd8) begin
            cur_bit = data_q[bit_cnt_q[2:0] - 3'd1];
        end else if (bit_cnt_q == 4'd9) begin
            cur_bit = par_q;
        end
    end

    always_comb begin
        tx_ready    = (state_q == IDLE);
        tx_busy     = (state_q != IDLE);
        ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQ);
        ps2_data_oe = (state_q == REQ) || ((state_q == SEND) && !cur_bit);
        tx_done     = done_q;
        tx_ack_err  = err_q;
        tx_timeout  = to_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Table-driven frames, randomized bytes, timeouts, reset abort and clock glitch.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int STO  = 500;
    localparam int PTO  = 1000;
    localparam int FLEN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_ack_err, tx_timeout;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES        (INH),
        .START_TIMEOUT_CYCLES  (STO),
        .PACKET_TIMEOUT_CYCLES (PTO),
        .FILTER_LEN            (FLEN)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_ack_err  (tx_ack_err),
        .tx_timeout  (tx_timeout),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int n_to = 0;
    int n_inh = 0;
    int req_cyc = 0;
    int to_cyc = 0;

    logic [10:0] samp_v;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ps2_clk_oe && !ps2_data_oe) n_inh = n_inh + 1;
        if (ps2_clk_oe && ps2_data_oe) req_cyc = cyc;
        if (tx_done) n_done = n_done + 1;
        if (tx_ack_err) n_err = n_err + 1;
        if (tx_timeout) begin
            n_to = n_to + 1;
            to_cyc = cyc;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_req(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device: samples data just before each falling edge, 40-cycle half period.
    task automatic dev_run(input int edges, input bit ack, input bit glitch);
        int w;
        w = 0;
        samp_v = '0;
        while (!(ps2_clk_in && !ps2_data_in) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("dev_start_seen", int'(w < 2000), 1);
        for (int k = 0; k < edges; k++) begin
            if (glitch && k == 4) begin
                repeat (5) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (12) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
            samp_v[k] = ps2_data_in;
            if (k == 10) dev_data = ack;
            repeat (20) @(negedge clk);
            dev_clk = 1'b0;
            repeat (40) @(negedge clk);
            dev_clk = 1'b1;
        end
        repeat (40) @(negedge clk);
        dev_data = 1'b1;
    endtask

    // exp_kind: 0 done, 1 ack error, 2 timeout
    task automatic run_txn(input logic [7:0] d, input bit ack, input int edges,
                           input bit glitch, input int exp_kind, input string tag);
        int d0, e0, t0, i0, w, lat;
        logic [10:0] mask, expf;
        d0 = n_done;
        e0 = n_err;
        t0 = n_to;
        i0 = n_inh;
        send_req(d);
        dev_run(edges, ack, glitch);
        w = 0;
        while (n_done + n_err + n_to == d0 + e0 + t0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_outcome_in_time"}, int'(w < 3000), 1);
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, n_done - d0, int'(exp_kind == 0));
        chk({tag, "_ack_err"}, n_err - e0, int'(exp_kind == 1));
        chk({tag, "_timeout"}, n_to - t0, int'(exp_kind == 2));
        chk({tag, "_inhibit_len"}, n_inh - i0, INH);
        chk({tag, "_busy"}, int'(tx_busy), 0);
        chk({tag, "_ready"}, int'(tx_ready), 1);
        chk({tag, "_oe"}, int'({ps2_clk_oe, ps2_data_oe}), 0);
        if (edges > 0) begin
            mask = 11'((1 << edges) - 1);
            expf = model_frame(d);
            chk({tag, "_frame"}, int'(samp_v & mask), int'(expf & mask));
        end else begin
            lat = to_cyc - req_cyc;
            chk({tag, "_start_to_lat_ok"},
                int'(lat >= STO - (FLEN + 3) && lat <= STO + FLEN + 3), 1);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        int         edges;
        bit         glitch;
        int         exp_kind;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int d0, e0, t0, w;
        logic [7:0] rd;
        bit         ra;

        vecs[0] = '{CMD_SET_LEDS, 1'b0, 11, 1'b0, 0};
        vecs[1] = '{CMD_ENABLE,   1'b1, 11, 1'b0, 1};
        vecs[2] = '{8'h00,        1'b0, 0,  1'b0, 2};
        vecs[3] = '{ACK_BYTE,     1'b0, 5,  1'b0, 2};
        vecs[4] = '{8'h55,        1'b0, 11, 1'b1, 0};

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("rst_pulses", int'({tx_done, tx_ack_err, tx_timeout}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].data, vecs[i].ack, vecs[i].edges,
                    vecs[i].glitch, vecs[i].exp_kind, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            run_txn(rd, ra, 11, 1'b0, ra ? 1 : 0, $sformatf("rnd%0d", i));
        end

        // Reset during bit 4 of CMD_RESET aborts with no pulse.
        d0 = n_done;
        e0 = n_err;
        t0 = n_to;
        send_req(CMD_RESET);
        fork
            dev_run(11, 1'b0, 1'b0);
            begin
                w = 0;
                while (!(ps2_clk_in && !ps2_data_in) && w < 2000) begin
                    @(negedge clk);
                    w++;
                end
                repeat (4 * 80 + 60) @(negedge clk);
                chk("abort_busy_before", int'(tx_busy), 1);
                rst_n = 1'b0;
                #1;
                chk("abort_oe_async", int'({ps2_clk_oe, ps2_data_oe}), 0);
                chk("abort_ready_in_rst", int'(tx_ready), 1);
                chk("abort_busy_in_rst", int'(tx_busy), 0);
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (100) @(negedge clk);
        chk("abort_no_pulse", (n_done - d0) + (n_err - e0) + (n_to - t0), 0);

        run_txn(8'h01, 1'b0, 11, 1'b0, 0, "post_rst");
        chk("post_rst_parity", int'(samp_v[9]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the shared open-drain PS/2 clock/data lines. Runs entirely in the system clock domain and samples the keyboard-generated PS/2 clock as data. Sits beside the keyboard receiver; tx_busy gates that receiver while a transmission is in progress.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles PS/2 clock is held low before the request (100 us at 50 MHz)
START_TIMEOUT_CYCLES, 750000, max cycles from clock release to first device falling edge (15 ms)
PACKET_TIMEOUT_CYCLES, 100000, max cycles from first falling edge to ACK edge (2 ms)
FILTER_LEN, 8, consecutive equal synchronized samples needed to change a filtered line value

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted when tx_valid && tx_ready
tx_ready  out  1  high only in IDLE
tx_busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse: device ACKed
tx_ack_err  out  1  one-cycle pulse: ACK bit sampled high
tx_timeout  out  1  one-cycle pulse: start or packet timeout
ps2_clk_in  in  1  raw PS/2 clock line
ps2_data_in  in  1  raw PS/2 data line
ps2_clk_oe  out  1  1 = drive PS/2 clock low, 0 = release
ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, both oe=0, tx_done/tx_ack_err/tx_timeout=0, counters 0, filtered lines=1. tx_ready=1 and tx_busy=0 while held in reset. Reset mid-transfer releases both lines immediately. No pulse is emitted.
- Inputs pass through a 2-FF synchronizer, then a FILTER_LEN filter. Falling edge = filtered clock 1->0, detected one cycle later.
- IDLE: oe=0. On accept, latch tx_data and compute odd parity (~^tx_data). Next state is INHIBIT. tx_valid is ignored outside IDLE.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then REQ.
- REQ (1 cycle): clk_oe=1, data_oe=1 (start bit 0). Then SEND. bit_cnt=0, timer cleared.
- SEND: clk_oe=0. data_oe = inverse of the current bit (bit 0 -> drive, bit 1 -> release). The start bit stays driven until the 1st falling edge. On falling edge n, bit_cnt increments:
  - n=1..8: present D0..D7 (LSB first)
  - n=9: present parity
  - n=10: stop bit, data_oe=0
  - n=11: sample filtered data. 0 -> ACK_WAIT with ack ok. 1 -> ACK_WAIT with ack error.
- ACK_WAIT: both oe=0. Wait for filtered clock=1 AND data=1 (bus idle). Then pulse tx_done or tx_ack_err for one cycle and go to IDLE.
- Timeouts: START_TIMEOUT_CYCLES runs from SEND entry until the 1st falling edge. PACKET_TIMEOUT_CYCLES runs from the 1st falling edge until the 11th. On expiry: both oe=0, pulse tx_timeout, go to IDLE, send no further bits. ACK_WAIT has no timeout beyond the packet timeout.
- Exactly one of tx_done/tx_ack_err/tx_timeout pulses per accepted request.
- Bit changes occur only on device falling edges; data_oe never changes while the filtered clock is low, except on abort.
- Timer width = $clog2(max parameter)+1. bit_cnt is 4 bits and never exceeds 11.

Decomposition:
- ps2_pkg:
  - state typedef enum {IDLE, INHIBIT, REQ, SEND, ACK_WAIT}
  - command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, ACK_BYTE=8'hFA
  - odd-parity function
- Sub-module ps2_line_filter (2-FF sync + FILTER_LEN stable-sample filter, reset value 1), instantiated once each for clock and data. It is reusable by the receiver.

Test Plan:
- Bench setup: INHIBIT_CYCLES=20, FILTER_LEN=4, device model with 40-cycle clock half-period.
- Send 0xED, device ACKs -> clk_oe high 20 cycles. Device samples 0,1,0,1,1,0,1,1,1,1,1 (start, D0..D7, parity=1, stop). tx_done pulses once. tx_busy is low after bus idle.
- Send 0xF4, device drives ACK=1 -> parity sampled 0; tx_ack_err pulses once, no tx_done.
- Device never clocks, START_TIMEOUT_CYCLES=500 -> tx_timeout pulses 500 cycles (±FILTER_LEN+3) after REQ. Both oe=0. tx_ready=1 next cycle.
- Device stops after 5 edges, PACKET_TIMEOUT_CYCLES=1000 -> tx_timeout pulses, lines released, no done/err.
- Assert reset low during bit 4 of 0xFF -> both oe=0 asynchronously (same cycle), no pulses. After release, send 0x01 succeeds with parity 0.
- 3-cycle glitch on ps2_clk_in during SEND -> no bit advance; the byte still arrives intact with tx_done.
